// File: rtl/servo_pwm_bank.sv
// Multi-channel servo PWM generator: one shared frame counter, per-channel
// compare that slews toward a loaded target by at most STEP counts per frame.
module servo_pwm_bank #(
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned CW       = 10,
   parameter int unsigned PERIOD   = 976,
   parameter int unsigned STEP     = 1,
   parameter int unsigned INIT_CCR = 82
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [CHANNELS*CW-1:0] target,
   input  logic [CHANNELS-1:0]    load,
   output logic [CHANNELS-1:0]    pwm,
   output logic                   frame,
   output logic [CHANNELS-1:0]    settled
);

   localparam logic [CW-1:0] CNT_MAX = CW'(PERIOD - 1);
   localparam logic [CW-1:0] CCR_RST = CW'(INIT_CCR);
   localparam logic [CW-1:0] STEP_CW = CW'(STEP);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   logic          boundary_c;

   logic [CW-1:0] pending      [CHANNELS];
   logic [CW-1:0] active       [CHANNELS];
   logic [CW-1:0] pending_next [CHANNELS];
   logic [CW-1:0] active_next  [CHANNELS];

   // Targets beyond the last count would mean "always high"; clamp them.
   function automatic logic [CW-1:0] clamp(input logic [CW-1:0] t);
      return (t > CNT_MAX) ? CNT_MAX : t;
   endfunction

   // STEP is only narrowed to CW bits on the path where it is smaller than diff.
   function automatic logic [CW-1:0] slew(input logic [CW-1:0] a,
                                          input logic [CW-1:0] p);
      logic [CW-1:0] diff;
      diff = (p > a) ? (p - a) : (a - p);
      if (STEP == 0 || 32'(diff) <= STEP) begin
         return p;
      end
      return (p > a) ? (a + STEP_CW) : (a - STEP_CW);
   endfunction

   always_comb begin
      boundary_c = (cnt == CNT_MAX);
      cnt_next   = boundary_c ? '0 : cnt + CW'(1);
   end

   // Boundary update uses the pending value from before this edge.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         pending_next[i] = load[i] ? clamp(target[i*CW +: CW]) : pending[i];
         active_next[i]  = boundary_c ? slew(active[i], pending[i]) : active[i];
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt     <= CNT_MAX;
         frame   <= 1'b0;
         pwm     <= '0;
         settled <= '1;
         for (int i = 0; i < CHANNELS; i++) begin
            pending[i] <= CCR_RST;
            active[i]  <= CCR_RST;
         end
      end else begin
         cnt   <= cnt_next;
         frame <= boundary_c;
         for (int i = 0; i < CHANNELS; i++) begin
            pending[i] <= pending_next[i];
            active[i]  <= active_next[i];
            pwm[i]     <= (cnt_next < active_next[i]);
            settled[i] <= (active_next[i] == pending_next[i]);
         end
      end
   end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Directed bench for servo_pwm_bank: one STEP=2 instance and one STEP=0 instance
// sharing clock and reset, CW=4, PERIOD=10, INIT_CCR=3.
module tb_servo_pwm_bank;

   localparam int unsigned CH     = 2;
   localparam int unsigned CW     = 4;
   localparam int unsigned PERIOD = 10;

   logic          CLK = 1'b0;
   logic          RST;
   logic [CH*CW-1:0] target, target0;
   logic [CH-1:0] load, load0;
   logic [CH-1:0] pwm, pwm0;
   logic          frame, frame0;
   logic [CH-1:0] settled, settled0;

   int n_checks = 0;
   int n_pass   = 0;

   servo_pwm_bank #(.CHANNELS(CH), .CW(CW), .PERIOD(PERIOD), .STEP(2), .INIT_CCR(3)) u_dut (
      .CLK(CLK), .RST(RST), .target(target), .load(load),
      .pwm(pwm), .frame(frame), .settled(settled)
   );

   servo_pwm_bank #(.CHANNELS(CH), .CW(CW), .PERIOD(PERIOD), .STEP(0), .INIT_CCR(3)) u_step0 (
      .CLK(CLK), .RST(RST), .target(target0), .load(load0),
      .pwm(pwm0), .frame(frame0), .settled(settled0)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Called at the cnt==0 sample; returns at the next cnt==0 sample.
   task automatic measure(output int w0, output int w1, output int v0, output int v1,
                          output int fr_in, output logic fr_end);
      w0 = int'(pwm[0]);  w1 = int'(pwm[1]);
      v0 = int'(pwm0[0]); v1 = int'(pwm0[1]);
      fr_in = 0;
      for (int i = 1; i < PERIOD; i++) begin
         tick();
         w0 += int'(pwm[0]);  w1 += int'(pwm[1]);
         v0 += int'(pwm0[0]); v1 += int'(pwm0[1]);
         fr_in += int'(frame);
      end
      tick();
      fr_end = frame;
   endtask

   task automatic test_reset();
      int w0, w1, v0, v1, fr_in;
      logic fr_end;
      #2 RST = 1'b1;
      #1;
      n_checks++; if (pwm !== 2'b00) $display("FAIL reset_pwm: got %b want 00", pwm); else n_pass++;
      n_checks++; if (frame !== 1'b0) $display("FAIL reset_frame: got %b want 0", frame); else n_pass++;
      n_checks++; if (settled !== 2'b11) $display("FAIL reset_settled: got %b want 11", settled); else n_pass++;
      n_checks++; if (pwm0 !== 2'b00 || settled0 !== 2'b11)
         $display("FAIL reset_step0: got pwm %b settled %b want 00 11", pwm0, settled0); else n_pass++;
      tick();
      tick();
      @(negedge CLK) RST = 1'b0;
      tick();
      n_checks++; if (frame !== 1'b1) $display("FAIL first_frame: got %b want 1", frame); else n_pass++;
      n_checks++; if (pwm !== 2'b11) $display("FAIL first_pwm: got %b want 11", pwm); else n_pass++;
      n_checks++; if (settled !== 2'b11) $display("FAIL first_settled: got %b want 11", settled); else n_pass++;
      measure(w0, w1, v0, v1, fr_in, fr_end);
      n_checks++; if (w0 != 3 || w1 != 3) $display("FAIL init_width: got %0d %0d want 3 3", w0, w1); else n_pass++;
      n_checks++; if (v0 != 3 || v1 != 3) $display("FAIL init_width_step0: got %0d %0d want 3 3", v0, v1); else n_pass++;
      n_checks++; if (fr_in != 0 || fr_end !== 1'b1)
         $display("FAIL frame_period: got inner %0d end %b want 0 1", fr_in, fr_end); else n_pass++;
   endtask

   task automatic test_slew_up();
      int w0, w1, v0, v1, fr_in;
      logic fr_end;
      int exp_w0 [3] = '{5, 7, 8};
      logic exp_s0 [3] = '{1'b0, 1'b0, 1'b1};
      repeat (4) tick();
      target = {4'd0, 4'd8};
      load   = 2'b01;
      tick();
      load   = 2'b00;
      n_checks++; if (settled !== 2'b10) $display("FAIL slew_load_settled: got %b want 10", settled); else n_pass++;
      repeat (5) tick();
      for (int k = 0; k < 3; k++) begin
         n_checks++; if (settled !== {1'b1, exp_s0[k]})
            $display("FAIL slew_settled[%0d]: got %b want %b", k, settled, {1'b1, exp_s0[k]}); else n_pass++;
         measure(w0, w1, v0, v1, fr_in, fr_end);
         n_checks++; if (w0 != exp_w0[k] || w1 != 3)
            $display("FAIL slew_width[%0d]: got %0d %0d want %0d 3", k, w0, w1, exp_w0[k]); else n_pass++;
      end
   endtask

   task automatic test_clamp_zero();
      int w0, w1, v0, v1, fr_in;
      logic fr_end;
      int exp_w0 [5] = '{6, 4, 2, 0, 0};
      int exp_w1 [5] = '{5, 7, 9, 9, 9};
      logic [1:0] exp_s [5] = '{2'b00, 2'b00, 2'b10, 2'b11, 2'b11};
      target = {4'd15, 4'd0};
      load   = 2'b11;
      tick();
      load   = 2'b00;
      n_checks++; if (settled !== 2'b00) $display("FAIL clamp_load_settled: got %b want 00", settled); else n_pass++;
      repeat (9) tick();
      for (int k = 0; k < 5; k++) begin
         n_checks++; if (settled !== exp_s[k])
            $display("FAIL clamp_settled[%0d]: got %b want %b", k, settled, exp_s[k]); else n_pass++;
         measure(w0, w1, v0, v1, fr_in, fr_end);
         n_checks++; if (w0 != exp_w0[k] || w1 != exp_w1[k])
            $display("FAIL clamp_width[%0d]: got %0d %0d want %0d %0d", k, w0, w1, exp_w0[k], exp_w1[k]); else n_pass++;
      end
   endtask

   task automatic test_boundary_race();
      int w0, w1, v0, v1, fr_in;
      logic fr_end;
      int exp_w0 [5] = '{0, 2, 4, 6, 7};
      logic exp_s0 [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      repeat (9) tick();
      target = {4'd15, 4'd7};
      load   = 2'b01;
      tick();
      load   = 2'b00;
      n_checks++; if (frame !== 1'b1) $display("FAIL race_frame: got %b want 1", frame); else n_pass++;
      for (int k = 0; k < 5; k++) begin
         n_checks++; if (settled !== {1'b1, exp_s0[k]})
            $display("FAIL race_settled[%0d]: got %b want %b", k, settled, {1'b1, exp_s0[k]}); else n_pass++;
         measure(w0, w1, v0, v1, fr_in, fr_end);
         n_checks++; if (w0 != exp_w0[k] || w1 != 9)
            $display("FAIL race_width[%0d]: got %0d %0d want %0d 9", k, w0, w1, exp_w0[k]); else n_pass++;
      end
   endtask

   task automatic test_step0();
      int w0, w1, v0, v1, fr_in;
      logic fr_end;
      repeat (3) tick();
      target0 = {4'd6, 4'd0};
      load0   = 2'b10;
      tick();
      load0   = 2'b00;
      n_checks++; if (settled0 !== 2'b01) $display("FAIL step0_load_settled: got %b want 01", settled0); else n_pass++;
      repeat (6) tick();
      n_checks++; if (settled0 !== 2'b11) $display("FAIL step0_settled: got %b want 11", settled0); else n_pass++;
      for (int k = 0; k < 2; k++) begin
         measure(w0, w1, v0, v1, fr_in, fr_end);
         n_checks++; if (v0 != 3 || v1 != 6)
            $display("FAIL step0_width[%0d]: got %0d %0d want 3 6", k, v0, v1); else n_pass++;
         n_checks++; if (w0 != 7 || w1 != 9)
            $display("FAIL step0_other[%0d]: got %0d %0d want 7 9", k, w0, w1); else n_pass++;
      end
   endtask

   task automatic test_async_reset();
      int w0, w1, v0, v1, fr_in;
      logic fr_end;
      tick();
      n_checks++; if (pwm[0] !== 1'b1) $display("FAIL arst_pre_pwm0: got %b want 1", pwm[0]); else n_pass++;
      RST = 1'b1;
      #1;
      n_checks++; if (pwm !== 2'b00 || pwm0 !== 2'b00)
         $display("FAIL arst_pwm: got %b %b want 00 00", pwm, pwm0); else n_pass++;
      n_checks++; if (frame !== 1'b0 || settled !== 2'b11 || settled0 !== 2'b11)
         $display("FAIL arst_state: got frame %b settled %b %b want 0 11 11", frame, settled, settled0); else n_pass++;
      tick();
      tick();
      @(negedge CLK) RST = 1'b0;
      tick();
      n_checks++; if (frame !== 1'b1 || pwm !== 2'b11)
         $display("FAIL arst_first: got frame %b pwm %b want 1 11", frame, pwm); else n_pass++;
      measure(w0, w1, v0, v1, fr_in, fr_end);
      n_checks++; if (w0 != 3 || w1 != 3 || v0 != 3 || v1 != 3)
         $display("FAIL arst_width: got %0d %0d %0d %0d want 3 3 3 3", w0, w1, v0, v1); else n_pass++;
      n_checks++; if (fr_in != 0 || fr_end !== 1'b1)
         $display("FAIL arst_frame: got inner %0d end %b want 0 1", fr_in, fr_end); else n_pass++;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      RST     = 1'b0;
      target  = '0;
      load    = '0;
      target0 = '0;
      load0   = '0;
      test_reset();
      test_slew_up();
      test_clamp_zero();
      test_boundary_race();
      test_step0();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
